bus_terminal_fifo: RTL

BUS_TERMINAL_FIFO -- requirements
Module: bus_terminal_fifo

---
 rtl/bus_pkg.sv | 13 +
 rtl/sync_fifo_fwft.sv | 66 ++++++
 rtl/bus_terminal_fifo.sv | 69 ++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared defaults and sizing helpers for the bus terminal queues.
package bus_pkg;

    localparam int PCKG_SZ_DEF   = 16;
    localparam int DEEP_FIFO_DEF = 8;
    localparam int CNT_W         = 8;

    // Occupancy must represent 0..depth inclusive, hence depth+1 states.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through queue: head is read straight from storage, so a
// packet written at one edge is visible right after it.
module sync_fifo_fwft
    import bus_pkg::*;
#(
    parameter int width = PCKG_SZ_DEF,
    parameter int depth = DEEP_FIFO_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [width-1:0]          din,
    input  logic                      rd,
    output logic [width-1:0]          head,
    output logic [occ_w(depth)-1:0]   count,
    output logic [CNT_W-1:0]          lost_cnt,
    output logic                      empty_rd
);

    localparam int cw = occ_w(depth);
    localparam int aw = $clog2(depth);
    localparam logic [cw-1:0]    full_lvl = cw'(depth);
    localparam logic [cw-1:0]    cnt_one  = cw'(1);
    localparam logic [aw-1:0]    ptr_one  = aw'(1);
    localparam logic [CNT_W-1:0] lost_one = CNT_W'(1);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wp, rp;
    logic             full, empty, do_wr, do_rd, drop;

    assign full  = (count == full_lvl);
    assign empty = (count == '0);
    assign do_rd = rd & ~empty;
    // A write into a full queue still lands if the head leaves this cycle.
    assign do_wr = wr & (~full | rd);
    assign drop  = wr & full & ~rd;

    assign head     = mem[rp];
    assign empty_rd = rd & empty;

    always_ff @(posedge clk) begin
        if (reset && do_wr)
            mem[wp] <= din;
    end

    // Pointers wrap for free because depth is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            lost_cnt <= '0;
        end else begin
            if (do_wr) wp <= wp + ptr_one;
            if (do_rd) rp <= rp + ptr_one;
            case ({do_wr, do_rd})
                2'b10:   count <= count + cnt_one;
                2'b01:   count <= count - cnt_one;
                default: count <= count;
            endcase
            if (drop && lost_cnt != '1)
                lost_cnt <= lost_cnt + lost_one;
        end
    end

endmodule

// File: rtl/bus_terminal_fifo.sv
// Bus terminal: TX queue from the upstream driver to the bus, RX queue from
// the bus to the downstream monitor. Packets pass through untouched.
module bus_terminal_fifo
    import bus_pkg::*;
#(
    parameter int pckg_sz   = PCKG_SZ_DEF,
    parameter int deep_fifo = DEEP_FIFO_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [pckg_sz-1:0]            wr_data,
    output logic                          tx_full,
    output logic                          pndng,
    output logic [pckg_sz-1:0]            D_pop,
    input  logic                          pop,
    input  logic                          push,
    input  logic [pckg_sz-1:0]            D_push,
    input  logic                          rd_en,
    output logic [pckg_sz-1:0]            rd_data,
    output logic                          rx_empty,
    output logic [occ_w(deep_fifo)-1:0]   tx_count,
    output logic [occ_w(deep_fifo)-1:0]   rx_count,
    output logic [CNT_W-1:0]              tx_ovf_cnt,
    output logic [CNT_W-1:0]              rx_drop_cnt,
    output logic                          pop_err
);

    localparam int cw = occ_w(deep_fifo);
    localparam logic [cw-1:0] full_lvl = cw'(deep_fifo);

    logic tx_empty_rd;
    logic rx_empty_rd_unused;

    sync_fifo_fwft #(.width(pckg_sz), .depth(deep_fifo)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr_en),
        .din      (wr_data),
        .rd       (pop),
        .head     (D_pop),
        .count    (tx_count),
        .lost_cnt (tx_ovf_cnt),
        .empty_rd (tx_empty_rd)
    );

    // RX reads on an empty queue are silently ignored.
    sync_fifo_fwft #(.width(pckg_sz), .depth(deep_fifo)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .wr       (push),
        .din      (D_push),
        .rd       (rd_en),
        .head     (rd_data),
        .count    (rx_count),
        .lost_cnt (rx_drop_cnt),
        .empty_rd (rx_empty_rd_unused)
    );

    assign pndng    = (tx_count != '0);
    assign tx_full  = (tx_count == full_lvl);
    assign rx_empty = (rx_count == '0);

    always_ff @(posedge clk) begin
        if (!reset) pop_err <= 1'b0;
        else        pop_err <= tx_empty_rd;
    end

endmodule
